// File: rtl/aclk_core_if.sv
// ---------------------------------------------------------------------------
// aclk_core_if
//  Config bus and display bus of the alarm-clock core, bundled so the core
//  and the bench share one connection point.
//
//  Bus protocol (no valid/ready pair): every input is level-sampled on each
//  rising clk edge. A load is a one-cycle-or-longer assertion of LD_time or
//  LD_alarm together with the H/M digits; it is accepted in that cycle iff
//  the digits form a legal HH:MM. Outputs are registered and always valid.
//
//  Signals
//    H_in1[1:0], H_in0/M_in1/M_in0[3:0]  digits for a load
//    LD_time, LD_alarm                    load strobes
//    AL_ON, STOP_al                       alarm enable / silence
//    Alarm                                alarm ringing
//    H_out1[1:0], H_out0, M_out1, M_out0, S_out1, S_out0 [3:0]  BCD time
//
//  Modports: master = config side (drives inputs), slave = core.
// ---------------------------------------------------------------------------
interface aclk_core_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       AL_ON;
  logic       STOP_al;

  logic       Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic [3:0] S_out1;
  logic [3:0] S_out0;

  modport master (
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, STOP_al,
    input  Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
  );

  modport slave (
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, STOP_al,
    output Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
  );
endinterface

// File: rtl/aclk_core.sv
// ---------------------------------------------------------------------------
// aclk_core
//  Alarm-clock timekeeping core. Divides clk by DIV into a 1 Hz tick, keeps
//  BCD time HH:MM:SS (00:00:00..23:59:59), stores an alarm HH:MM and rings
//  when enabled time reaches alarm:00.
//
//  Ports
//    clk      in  system clock (DIV cycles per second), posedge
//    reset    in  synchronous, active-low reset
//    bus      aclk_core_if.slave  config inputs and registered digit outputs
//    o_state  out alarm FSM state (debug)
//
//  Parameters
//    DIV      clk cycles per second, >= 2
// ---------------------------------------------------------------------------
module aclk_core #(
  parameter int DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  aclk_core_if.slave  bus,
  output logic [1:0]  o_state
);

  localparam int PW = (DIV <= 2) ? 1 : $clog2(DIV);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RINGING  = 2'd1,
    ST_SILENCED = 2'd2
  } state_t;

  logic [PW-1:0] r_pre;
  logic [1:0]    r_h1;
  logic [3:0]    r_h0, r_m1, r_m0, r_s1, r_s0;
  logic [1:0]    r_ah1;
  logic [3:0]    r_ah0, r_am1, r_am0;
  state_t        r_state;
  logic          r_alarm;

  logic          w_tick;
  logic          w_ld_ok;
  logic          w_same_min;
  logic          w_match;
  logic [1:0]    w_h1;
  logic [3:0]    w_h0, w_m1, w_m0, w_s1, w_s0;

  assign w_tick = (r_pre == PW'(DIV - 1));

  // A load is legal only as a whole; any bad digit rejects it completely.
  assign w_ld_ok = (bus.H_in1 <= 2'd2) &&
                   ((bus.H_in1 == 2'd2) ? (bus.H_in0 <= 4'd3) : (bus.H_in0 <= 4'd9)) &&
                   (bus.M_in1 <= 4'd5) && (bus.M_in0 <= 4'd9);

  assign w_same_min = (r_h1 == r_ah1) && (r_h0 == r_ah0) &&
                      (r_m1 == r_am1) && (r_m0 == r_am0);

  // Uses registered time, so a time load that lands on the alarm also rings.
  assign w_match = bus.AL_ON && w_same_min && (r_s1 == 4'd0) && (r_s0 == 4'd0);

  // Time + 1 s with BCD carries; hours wrap 23 -> 00.
  always_comb begin
    w_h1 = r_h1;
    w_h0 = r_h0;
    w_m1 = r_m1;
    w_m0 = r_m0;
    w_s1 = r_s1;
    w_s0 = r_s0;
    if (r_s0 != 4'd9) begin
      w_s0 = r_s0 + 4'd1;
    end else begin
      w_s0 = 4'd0;
      if (r_s1 != 4'd5) begin
        w_s1 = r_s1 + 4'd1;
      end else begin
        w_s1 = 4'd0;
        if (r_m0 != 4'd9) begin
          w_m0 = r_m0 + 4'd1;
        end else begin
          w_m0 = 4'd0;
          if (r_m1 != 4'd5) begin
            w_m1 = r_m1 + 4'd1;
          end else begin
            w_m1 = 4'd0;
            if ((r_h1 == 2'd2) && (r_h0 == 4'd3)) begin
              w_h1 = 2'd0;
              w_h0 = 4'd0;
            end else if (r_h0 == 4'd9) begin
              w_h1 = r_h1 + 2'd1;
              w_h0 = 4'd0;
            end else begin
              w_h0 = r_h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Prescaler, time and alarm registers. A valid time load wins over a tick
  // and restarts the prescaler so the next second is a full DIV cycles away.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre <= '0;
      r_h1  <= 2'd0;
      r_h0  <= 4'd0;
      r_m1  <= 4'd0;
      r_m0  <= 4'd0;
      r_s1  <= 4'd0;
      r_s0  <= 4'd0;
      r_ah1 <= 2'd0;
      r_ah0 <= 4'd0;
      r_am1 <= 4'd0;
      r_am0 <= 4'd0;
    end else begin
      if (bus.LD_time && w_ld_ok) begin
        r_pre <= '0;
        r_h1  <= bus.H_in1;
        r_h0  <= bus.H_in0;
        r_m1  <= bus.M_in1;
        r_m0  <= bus.M_in0;
        r_s1  <= 4'd0;
        r_s0  <= 4'd0;
      end else begin
        r_pre <= w_tick ? '0 : r_pre + PW'(1);
        if (w_tick) begin
          r_h1 <= w_h1;
          r_h0 <= w_h0;
          r_m1 <= w_m1;
          r_m0 <= w_m0;
          r_s1 <= w_s1;
          r_s0 <= w_s0;
        end
      end
      if (bus.LD_alarm && w_ld_ok) begin
        r_ah1 <= bus.H_in1;
        r_ah0 <= bus.H_in0;
        r_am1 <= bus.M_in1;
        r_am0 <= bus.M_in0;
      end
    end
  end

  // Alarm FSM. SILENCED holds off re-ringing until the minute moves away
  // from the alarm minute (or the alarm is disabled).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_alarm <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            r_state <= ST_RINGING;
            r_alarm <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (!bus.AL_ON) begin
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
          end else if (bus.STOP_al) begin
            r_state <= ST_SILENCED;
            r_alarm <= 1'b0;
          end
        end
        ST_SILENCED: begin
          if (!w_same_min || !bus.AL_ON) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Alarm  = r_alarm;
  assign bus.H_out1 = r_h1;
  assign bus.H_out0 = r_h0;
  assign bus.M_out1 = r_m1;
  assign bus.M_out0 = r_m0;
  assign bus.S_out1 = r_s1;
  assign bus.S_out0 = r_s0;
  assign o_state    = r_state;

endmodule

// File: tb/tb_aclk_core.sv
// ---------------------------------------------------------------------------
// tb_aclk_core
//  Directed bench for aclk_core. The driver pushes the hand-computed display
//  (Alarm + HH:MM:SS) expected after each posedge; a monitor compares it at
//  the following negedge.
// ---------------------------------------------------------------------------
module tb_aclk_core;
  localparam int DIV = 10;
  localparam int W   = 23;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  aclk_core_if bus();

  aclk_core #(.DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks;
  int           failures;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  string        mon_tag;

  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        mon_act = {bus.Alarm, bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0,
                   bus.S_out1, bus.S_out0};
        checks++;
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL %s: got alarm=%0d %0d%0d:%0d%0d:%0d%0d required alarm=%0d %0d%0d:%0d%0d:%0d%0d",
                   mon_tag, mon_act[22], mon_act[21:20], mon_act[19:16], mon_act[15:12],
                   mon_act[11:8], mon_act[7:4], mon_act[3:0],
                   mon_exp[22], mon_exp[21:20], mon_exp[19:16], mon_exp[15:12],
                   mon_exp[11:8], mon_exp[7:4], mon_exp[3:0]);
        end
      end
    end
  end

  // Watchdog: the directed sequence is a fixed cycle count, this only guards
  // against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of sequence required end within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic al, input logic [1:0] h1,
                     input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0,
                     input logic [3:0] s1, input logic [3:0] s0);
    exp_q.push_back({al, h1, h0, m1, m0, s1, s0});
    tag_q.push_back(tag);
  endtask

  task automatic ld(input logic lt, input logic la, input logic [1:0] h1,
                    input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
    bus.H_in1    = h1;
    bus.H_in0    = h0;
    bus.M_in1    = m1;
    bus.M_in0    = m0;
    bus.LD_time  = lt;
    bus.LD_alarm = la;
    cyc(1);
    bus.LD_time  = 1'b0;
    bus.LD_alarm = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.STOP_al = 1'b1;
    cyc(1);
    bus.STOP_al = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b0;
    bus.H_in1    = 2'd0;
    bus.H_in0    = 4'd0;
    bus.M_in1    = 4'd0;
    bus.M_in0    = 4'd0;
    bus.LD_time  = 1'b0;
    bus.LD_alarm = 1'b0;
    bus.AL_ON    = 1'b0;
    bus.STOP_al  = 1'b0;

    // 1. reset, then ten seconds of free running
    cyc(3);
    chk("reset", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;
    cyc(10 * DIV);
    chk("run_10s", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);

    // 2. load 23:59, first tick exactly DIV cycles later, full day wrap
    ld(1, 0, 2'd2, 4'd3, 4'd5, 4'd9);
    chk("ld_2359", 0, 2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd0);
    cyc(DIV - 1);
    chk("pre_tick", 0, 2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd0);
    cyc(1);
    chk("first_tick", 0, 2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd1);
    cyc(59 * DIV);
    chk("day_wrap", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(10 * DIV);
    chk("after_wrap", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);

    // 3. invalid time loads change nothing, prescaler keeps counting
    ld(1, 0, 2'd2, 4'd4, 4'd0, 4'd0);
    chk("bad_h24", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
    ld(1, 0, 2'd1, 4'd2, 4'd6, 4'd0);
    chk("bad_m60", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
    cyc(DIV - 3);
    chk("bad_no_clr", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
    cyc(1);
    chk("bad_tick", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1);
    // valid alarm 19:45, then an invalid alarm load that must be ignored
    ld(0, 1, 2'd1, 4'd9, 4'd4, 4'd5);
    ld(0, 1, 2'd2, 4'd4, 4'd0, 4'd0);
    bus.AL_ON = 1'b1;
    ld(1, 0, 2'd1, 4'd9, 4'd4, 4'd5);
    chk("al19_ld", 0, 2'd1, 4'd9, 4'd4, 4'd5, 4'd0, 4'd0);
    cyc(1);
    chk("al19_ring", 1, 2'd1, 4'd9, 4'd4, 4'd5, 4'd0, 4'd0);
    bus.AL_ON = 1'b0;
    cyc(1);
    chk("al_off", 0, 2'd1, 4'd9, 4'd4, 4'd5, 4'd0, 4'd0);

    // 4. alarm 07:30 reached by counting, rings past its minute
    ld(0, 1, 2'd0, 4'd7, 4'd3, 4'd0);
    bus.AL_ON = 1'b1;
    ld(1, 0, 2'd0, 4'd7, 4'd2, 4'd9);
    chk("ld_0729", 0, 2'd0, 4'd7, 4'd2, 4'd9, 4'd0, 4'd0);
    cyc(60 * DIV);
    chk("hit_0730", 0, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    cyc(1);
    chk("ring_0730", 1, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    cyc(649);
    chk("ring_0731", 1, 2'd0, 4'd7, 4'd3, 4'd1, 4'd0, 4'd5);
    stop_pulse();
    chk("stop_0731", 0, 2'd0, 4'd7, 4'd3, 4'd1, 4'd0, 4'd5);

    // 5. silence holds for the rest of the minute and across a same-minute reload
    ld(1, 0, 2'd0, 4'd7, 4'd3, 4'd0);
    chk("reld_0730", 0, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    cyc(1);
    chk("reld_ring", 1, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    cyc(29);
    chk("ring_03", 1, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd3);
    stop_pulse();
    chk("stop_03", 0, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd3);
    cyc(559);
    chk("quiet_59", 0, 2'd0, 4'd7, 4'd3, 4'd0, 4'd5, 4'd9);
    ld(1, 0, 2'd0, 4'd7, 4'd3, 4'd0);
    chk("same_min_ld", 0, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    cyc(1);
    chk("same_min_q", 0, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    ld(1, 0, 2'd0, 4'd7, 4'd3, 4'd1);
    chk("move_0731", 0, 2'd0, 4'd7, 4'd3, 4'd1, 4'd0, 4'd0);
    ld(1, 0, 2'd0, 4'd7, 4'd3, 4'd0);
    chk("back_0730", 0, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    cyc(1);
    chk("rering", 1, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);

    // 6. simultaneous time+alarm load, then reset mid-ring
    bus.AL_ON = 1'b0;
    ld(1, 0, 2'd0, 4'd8, 4'd0, 4'd0);
    chk("off_0800", 0, 2'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0);
    bus.AL_ON = 1'b1;
    ld(1, 1, 2'd1, 4'd2, 4'd0, 4'd0);
    chk("both_1200", 0, 2'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(1);
    chk("both_ring", 1, 2'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
    reset = 1'b0;
    cyc(1);
    chk("rst_ring", 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;
    cyc(1);
    chk("rst_rering", 1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    cyc(2);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
